// File: rtl/accum_scheduler_if.sv
// Requester-side handshake bundle for accum_scheduler: per-requester valid/data in, one-hot ready out.
interface accum_scheduler_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;

  // Requesters drive valid/data and observe ready.
  modport master (output req_valid, output req_data, input req_ready);
  // Scheduler observes valid/data and drives ready.
  modport slave (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/accum_scheduler.sv
// Round-robin scheduler sharing one accumulator among N_REQ requesters, with a one-cycle clear sequence.
module accum_scheduler #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear_req,
  accum_scheduler_if.slave         req_bus,
  output logic [WIDTH-1:0]         acc_value,
  output logic                     acc_overflow,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     grant_valid,
  output logic                     clear_done
);
  localparam int unsigned ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, CLEAR = 2'd2} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [ID_W-1:0]  rr_ptr;
  logic [N_REQ-1:0] ready_c;
  logic             found_c;
  logic [ID_W-1:0]  idx_c;
  logic [ID_W-1:0]  sel_id_c;
  logic [WIDTH-1:0] sel_data_c;
  logic [WIDTH:0]   sum_c;
  logic             xfer_c;

  // Next-state logic; clear_req outranks enable and CLEAR always lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (clear_req)   state_d = CLEAR;
        else if (enable) state_d = RUN;
      end
      RUN: begin
        if (clear_req)    state_d = CLEAR;
        else if (!enable) state_d = IDLE;
      end
      CLEAR:   state_d = enable ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Round-robin search from rr_ptr; first valid requester wins, only in RUN without a clear.
  always_comb begin
    ready_c = '0;
    found_c = 1'b0;
    idx_c   = '0;
    if (state_q == RUN && !clear_req) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        idx_c = ID_W'((32'(rr_ptr) + k) % N_REQ);
        if (!found_c && req_bus.req_valid[idx_c]) begin
          ready_c[idx_c] = 1'b1;
          found_c        = 1'b1;
        end
      end
    end
  end

  // Mux out the winning addend and its index, and form the carry-extended sum.
  always_comb begin
    sel_id_c   = '0;
    sel_data_c = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (ready_c[i]) begin
        sel_id_c   = ID_W'(i);
        sel_data_c = req_bus.req_data[i*WIDTH +: WIDTH];
      end
    end
    sum_c  = {1'b0, acc_value} + {1'b0, sel_data_c};
    xfer_c = |(req_bus.req_valid & ready_c);
  end

  assign req_bus.req_ready = ready_c;

  // State register, accumulator, pointer and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      acc_value    <= '0;
      acc_overflow <= 1'b0;
      rr_ptr       <= '0;
      grant_id     <= '0;
      grant_valid  <= 1'b0;
      clear_done   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_valid <= xfer_c;
      clear_done  <= (state_q == CLEAR);
      if (state_q == CLEAR) begin
        acc_value    <= '0;
        acc_overflow <= 1'b0;
      end else if (xfer_c) begin
        acc_value <= sum_c[WIDTH-1:0];
        if (sum_c[WIDTH]) acc_overflow <= 1'b1;
      end
      if (xfer_c) begin
        grant_id <= sel_id_c;
        rr_ptr   <= ID_W'((32'(sel_id_c) + 32'd1) % N_REQ);
      end
    end
  end
endmodule

// File: tb/tb_accum_scheduler.sv
// Directed self-checking bench for accum_scheduler (N_REQ=4, WIDTH=8).
module tb_accum_scheduler;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned WIDTH = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       clear_req;
  logic [7:0] acc_value;
  logic       acc_overflow;
  logic [1:0] grant_id;
  logic       grant_valid;
  logic       clear_done;

  int checks = 0;
  int errors = 0;

  accum_scheduler_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  accum_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .clear_req    (clear_req),
    .req_bus      (bus),
    .acc_value    (acc_value),
    .acc_overflow (acc_overflow),
    .grant_id     (grant_id),
    .grant_valid  (grant_valid),
    .clear_done   (clear_done)
  );

  always #5 clock = ~clock;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are sampled here.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [7:0] d);
    bus.req_data[idx*8 +: 8] = d;
  endtask

  initial begin
    reset         = 1'b1;
    enable        = 1'b0;
    clear_req     = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    step();
    step();
    check("rst_acc", 32'(acc_value), 0);
    check("rst_ovf", 32'(acc_overflow), 0);
    check("rst_gv", 32'(grant_valid), 0);
    check("rst_gid", 32'(grant_id), 0);
    check("rst_cd", 32'(clear_done), 0);
    check("rst_ready", 32'(bus.req_ready), 0);

    // Enable with nothing valid.
    reset  = 1'b0;
    enable = 1'b1;
    step();
    #1;
    check("idle_ready", 32'(bus.req_ready), 0);
    check("idle_acc", 32'(acc_value), 0);
    check("idle_gv", 32'(grant_valid), 0);

    // Requester 1 alone adds 0x48.
    bus.req_valid = 4'b0010;
    set_data(1, 8'h48);
    #1;
    check("r1_ready", 32'(bus.req_ready), 32'h2);
    step();
    bus.req_valid = '0;
    check("r1_acc", 32'(acc_value), 72);
    check("r1_gid", 32'(grant_id), 1);
    check("r1_gv", 32'(grant_valid), 1);
    step();
    check("r1_gv_drop", 32'(grant_valid), 0);

    // Reset back to a known pointer, then all four valid for eight cycles.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 4; i++) set_data(i, 8'(i + 1));
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("rr_ready%0d", k), 32'(bus.req_ready), 32'(1 << (k % 4)));
      step();
      check($sformatf("rr_gid%0d", k), 32'(grant_id), 32'(k % 4));
      check($sformatf("rr_gv%0d", k), 32'(grant_valid), 1);
    end
    bus.req_valid = '0;
    check("rr_acc", 32'(acc_value), 20);
    check("rr_ovf", 32'(acc_overflow), 0);

    // Bring acc to 0xF0 via requester 0 (pointer is back at 0).
    bus.req_valid = 4'b0001;
    set_data(0, 8'hDC);
    step();
    bus.req_valid = '0;
    check("pre_acc", 32'(acc_value), 32'hF0);
    check("pre_ovf", 32'(acc_overflow), 0);

    // Requester 2 adds 0x20 -> wrap with carry.
    bus.req_valid = 4'b0100;
    set_data(2, 8'h20);
    #1;
    check("wrap_ready", 32'(bus.req_ready), 32'h4);
    step();
    bus.req_valid = '0;
    check("wrap_acc", 32'(acc_value), 32'h10);
    check("wrap_ovf", 32'(acc_overflow), 1);
    check("wrap_gid", 32'(grant_id), 2);

    // Requester 3 adds 0x01; overflow stays sticky.
    bus.req_valid = 4'b1000;
    set_data(3, 8'h01);
    step();
    bus.req_valid = '0;
    check("sticky_acc", 32'(acc_value), 32'h11);
    check("sticky_ovf", 32'(acc_overflow), 1);

    // Clear while requester 0 is valid.
    bus.req_valid = 4'b0001;
    set_data(0, 8'h05);
    clear_req = 1'b1;
    #1;
    check("clr_ready_run", 32'(bus.req_ready), 0);
    step();
    clear_req = 1'b0;
    #1;
    check("clr_ready_clear", 32'(bus.req_ready), 0);
    check("clr_gv", 32'(grant_valid), 0);
    step();
    check("clr_acc", 32'(acc_value), 0);
    check("clr_ovf", 32'(acc_overflow), 0);
    check("clr_done", 32'(clear_done), 1);
    #1;
    check("post_clr_ready", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = '0;
    check("post_clr_acc", 32'(acc_value), 5);
    check("post_clr_gid", 32'(grant_id), 0);
    check("post_clr_gv", 32'(grant_valid), 1);
    check("post_clr_done", 32'(clear_done), 0);

    // Reset in the same cycle as a transfer of 36 from requester 3.
    bus.req_valid = 4'b1000;
    set_data(3, 8'd36);
    #1;
    check("rx_ready", 32'(bus.req_ready), 32'h8);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rx_acc", 32'(acc_value), 0);
    check("rx_gv", 32'(grant_valid), 0);
    bus.req_valid = 4'b1010;
    #1;
    check("rx_idle_ready", 32'(bus.req_ready), 0);
    step();
    check("rx_gv2", 32'(grant_valid), 0);
    #1;
    check("rx_ptr_ready", 32'(bus.req_ready), 32'h2);

    // enable falls in RUN: that cycle still grants, then IDLE.
    bus.req_valid = 4'b0010;
    set_data(1, 8'd3);
    enable = 1'b0;
    step();
    check("en_fall_acc", 32'(acc_value), 3);
    check("en_fall_gv", 32'(grant_valid), 1);
    #1;
    check("en_fall_ready", 32'(bus.req_ready), 0);
    bus.req_valid = '0;

    // Reset mid-CLEAR suppresses clear_done.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    reset     = 1'b1;
    step();
    reset = 1'b0;
    check("rclr_done", 32'(clear_done), 0);
    check("rclr_acc", 32'(acc_value), 0);
    step();
    check("rclr_done2", 32'(clear_done), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
